// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - shared widths, opcodes and multiply FSM encoding for the execute stage
package exe_stage_pkg;
  localparam int DSIZE = 16;
  localparam int ISIZE = 16;
  localparam int ASIZE = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;
  localparam logic [3:0] OP_BEQ = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;
endpackage

// File: rtl/exe_stage_mul.sv
// rtl/exe_stage_mul.sv - iterative shift-add multiplier, one partial product per cycle
module seq_mul #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);
  import exe_stage_pkg::*;

  localparam int CNT_W = $clog2(W);

  mul_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     mcand, mplier, acc;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          busy     = 1'b1;
          state_nx = S_BUSY;
        end
      end
      S_BUSY: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= CNT_W'(W - 1);
      end else if (state == S_BUSY) begin
        // only the low W bits of the product survive, so mcand may shift out freely
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

  assign product = acc;
endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, branch resolve, multi-cycle multiply and EXE/MEM register
module exe_stage #(
  parameter int DSIZE = exe_stage_pkg::DSIZE,
  parameter int ISIZE = exe_stage_pkg::ISIZE,
  parameter int ASIZE = exe_stage_pkg::ASIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] rdata1_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [DSIZE-1:0] imm_in,
  input  logic [3:0]       opcode_in,
  input  logic             alusrc_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             branch_in,
  input  logic             memRead_in,
  input  logic             memWrite_in,
  input  logic             memtoReg_in,
  input  logic             wen_in,
  input  logic [ISIZE-1:0] pc_in,
  output logic [DSIZE-1:0] alu_result_out,
  output logic [DSIZE-1:0] wdata_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             memRead_out,
  output logic             memWrite_out,
  output logic             memtoReg_out,
  output logic             wen_out,
  output logic             branch_taken_out,
  output logic [ISIZE-1:0] branch_target_out,
  output logic             stall_out
);
  import exe_stage_pkg::*;

  logic [DSIZE-1:0] op_b, alu_res, mul_product;
  logic [ISIZE-1:0] target;
  logic             is_mul, is_beq, in_mul, start_fire, mul_busy, mul_done;

  logic [DSIZE-1:0] h_wdata;
  logic [ASIZE-1:0] h_waddr;
  logic [ISIZE-1:0] h_target;
  logic             h_mr, h_mw, h_mtr, h_wen;

  assign op_b       = alusrc_in ? imm_in : rdata2_in;
  assign is_mul     = (opcode_in == OP_MUL);
  assign is_beq     = (opcode_in == OP_BEQ);
  assign target     = pc_in + imm_in[ISIZE-1:0];
  // in_mul stays high through DONE so the still-present MUL cannot restart the multiplier
  assign start_fire = is_mul & ~in_mul;
  assign stall_out  = mul_busy & rst;

  seq_mul #(.W(DSIZE)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (start_fire),
    .a       (rdata1_in),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_res = '0;
    case (opcode_in)
      OP_ADD, OP_LW, OP_SW: alu_res = rdata1_in + op_b;
      OP_SUB:               alu_res = rdata1_in - op_b;
      OP_AND:               alu_res = rdata1_in & op_b;
      OP_OR:                alu_res = rdata1_in | op_b;
      OP_XOR:               alu_res = rdata1_in ^ op_b;
      OP_SLL:               alu_res = rdata1_in << op_b[3:0];
      OP_SRL:               alu_res = rdata1_in >> op_b[3:0];
      default:              alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_mul   <= 1'b0;
      h_wdata  <= '0;
      h_waddr  <= '0;
      h_target <= '0;
      h_mr     <= 1'b0;
      h_mw     <= 1'b0;
      h_mtr    <= 1'b0;
      h_wen    <= 1'b0;
    end else begin
      if (mul_done) in_mul <= 1'b0;
      else if (start_fire) in_mul <= 1'b1;
      if (start_fire) begin
        h_wdata  <= rdata2_in;
        h_waddr  <= waddr_in;
        h_target <= target;
        h_mr     <= memRead_in;
        h_mw     <= memWrite_in;
        h_mtr    <= memtoReg_in;
        h_wen    <= wen_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_out    <= '0;
      wdata_out         <= '0;
      waddr_out         <= '0;
      memRead_out       <= 1'b0;
      memWrite_out      <= 1'b0;
      memtoReg_out      <= 1'b0;
      wen_out           <= 1'b0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
    end else if (mul_done) begin
      alu_result_out    <= mul_product;
      wdata_out         <= h_wdata;
      waddr_out         <= h_waddr;
      memRead_out       <= h_mr;
      memWrite_out      <= h_mw;
      memtoReg_out      <= h_mtr;
      wen_out           <= h_wen;
      branch_taken_out  <= 1'b0;
      branch_target_out <= h_target;
    end else if (stall_out) begin
      alu_result_out    <= '0;
      wdata_out         <= '0;
      waddr_out         <= '0;
      memRead_out       <= 1'b0;
      memWrite_out      <= 1'b0;
      memtoReg_out      <= 1'b0;
      wen_out           <= 1'b0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
    end else begin
      alu_result_out    <= alu_res;
      wdata_out         <= rdata2_in;
      waddr_out         <= waddr_in;
      memRead_out       <= memRead_in & ~is_beq;
      memWrite_out      <= memWrite_in & ~is_beq;
      memtoReg_out      <= memtoReg_in;
      wen_out           <= wen_in & ~is_beq;
      branch_taken_out  <= is_beq & branch_in & (rdata1_in == rdata2_in);
      branch_target_out <= target;
    end
  end
endmodule
